sram16_responder: RTL and testbench

- Responder model of the 16-bit RAM port that the memory controller drives. It answers `mc_ram_addr`, `mc_ram_wre` and `mc_ram_data` exactly as the physical RAM would, so the full core can run in simulation and on the FPGA with on-chip storage.
- After reset it self-clears its storage, then serves half-word reads and writes with a configurable read latency.
- It reports out-of-range accesses through a sticky flag.

---
 rtl/sram16_responder_if.sv | 25 ++
 rtl/sram16_responder.sv | 96 +++++++++
 tb/tb_sram16_responder.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram16_responder_if.sv
// Controller-side address/control and status signals of the external 16-bit RAM port.
// dbg_state is high while the responder is serving accesses, low while it self-clears.
interface sram16_responder_if;
    logic [17:0] mc_ram_addr;
    logic        mc_ram_wre;
    logic        ram_ready;
    logic        ram_oob;
    logic        dbg_state;

    modport master (
        output mc_ram_addr,
        output mc_ram_wre,
        input  ram_ready,
        input  ram_oob,
        input  dbg_state
    );

    modport slave (
        input  mc_ram_addr,
        input  mc_ram_wre,
        output ram_ready,
        output ram_oob,
        output dbg_state
    );
endinterface

// File: rtl/sram16_responder.sv
// Stand-in for the controller's external 16-bit RAM: self-clears after reset,
// then serves half-word reads/writes with a 0- or 1-cycle read latency.
module sram16_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int READ_LAT   = 0
) (
    input  logic              clock,
    input  logic              reset,
    sram16_responder_if.slave bus,
    inout  wire  [15:0]       mc_ram_data
);
    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] CLR_LAST = '1;
    localparam bit                    LAT1     = (READ_LAT == 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

    state_e                state_q;
    logic [DEPTH_LOG2-1:0] clr_cnt_q;
    logic                  ready_q;
    logic                  oob_q;
    logic                  rd_valid_q;
    logic [15:0]           rdata_q;
    logic [15:0]           mem [DEPTH];

    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;
    logic                  serving;
    logic [15:0]           rd_word;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_idx;
    logic [15:0]           mem_wdata;
    logic                  drive_en;
    logic [15:0]           drive_data;

    assign idx      = bus.mc_ram_addr[DEPTH_LOG2-1:0];
    assign in_range = (bus.mc_ram_addr >> DEPTH_LOG2) == 18'd0;
    assign serving  = (state_q == ST_SERVE);

    // Until the clear is done the storage is only partly zeroed, so reads are forced to 0.
    assign rd_word = (serving && in_range) ? mem[idx] : 16'h0000;

    // The clear sweep owns the single write port; controller writes only land once serving.
    assign mem_we    = !serving || (!bus.mc_ram_wre && in_range);
    assign mem_idx   = serving ? idx : clr_cnt_q;
    assign mem_wdata = serving ? mc_ram_data : 16'h0000;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            ready_q    <= 1'b0;
            oob_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rdata_q    <= 16'h0000;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == CLR_LAST) begin
                        state_q <= ST_SERVE;
                        ready_q <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (!in_range) begin
                        oob_q <= 1'b1;
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
            rd_valid_q <= bus.mc_ram_wre;
            if (bus.mc_ram_wre) begin
                rdata_q <= rd_word;
            end
        end
    end

    // With registered reads the first read cycle after a write stays undriven (bus turnaround).
    assign drive_data = LAT1 ? rdata_q : rd_word;
    assign drive_en   = reset && bus.mc_ram_wre && (!LAT1 || rd_valid_q);

    assign mc_ram_data   = drive_en ? drive_data : 16'hzzzz;
    assign bus.ram_ready = ready_q;
    assign bus.ram_oob   = oob_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_sram16_responder.sv
// Exercises a combinational-read and a registered-read responder side by side on
// identical stimulus, comparing both against a behavioural RAM model.
module tb_sram16_responder;
    localparam int DL2   = 4;
    localparam int DEPTH = 16;

    logic        clock    = 1'b0;
    logic        rst_n    = 1'b1;
    logic        tb_wre   = 1'b1;
    logic        tb_drv   = 1'b0;
    logic [17:0] tb_addr  = '0;
    logic [15:0] tb_wdata = '0;

    tri1 [15:0] bus0;
    tri1 [15:0] bus1;

    sram16_responder_if if0 ();
    sram16_responder_if if1 ();

    assign if0.mc_ram_addr = tb_addr;
    assign if0.mc_ram_wre  = tb_wre;
    assign if1.mc_ram_addr = tb_addr;
    assign if1.mc_ram_wre  = tb_wre;
    assign bus0 = tb_drv ? tb_wdata : 16'hzzzz;
    assign bus1 = tb_drv ? tb_wdata : 16'hzzzz;

    sram16_responder #(.DEPTH_LOG2(DL2), .READ_LAT(0)) u_lat0 (
        .clock       (clock),
        .reset       (rst_n),
        .bus         (if0),
        .mc_ram_data (bus0)
    );

    sram16_responder #(.DEPTH_LOG2(DL2), .READ_LAT(1)) u_lat1 (
        .clock       (clock),
        .reset       (rst_n),
        .bus         (if1),
        .mc_ram_data (bus1)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: RAM contents, status flags and the registered-read pipeline.
    logic [15:0] model_mem [DEPTH];
    logic        model_ready = 1'b0;
    logic        model_oob   = 1'b0;
    int          clear_cnt   = 0;
    logic [15:0] exp_q[$];

    logic [15:0] obs_bus0, obs_bus1, exp_bus0, exp_bus1;
    logic [3:0]  obs_flags, exp_flags;

    task automatic model_reset();
        model_ready = 1'b0;
        model_oob   = 1'b0;
        clear_cnt   = 0;
        exp_q.delete();
    endtask

    // One bus cycle, entered just after a rising edge. A write of 16'hFFFF is
    // supplied by the pull-up alone, so the bus must be left undriven by the DUT.
    task automatic drive_cycle(input logic wre, input logic [17:0] addr, input logic [15:0] wdata);
        logic        inr;
        logic [3:0]  idx;
        logic [15:0] rv;
        tb_wre   = wre;
        tb_addr  = addr;
        tb_wdata = wdata;
        tb_drv   = !wre && (wdata != 16'hFFFF);
        inr = (addr < 18'(DEPTH));
        idx = addr[3:0];
        rv  = (model_ready && inr) ? model_mem[idx] : 16'h0000;
        @(negedge clock);
        obs_bus0  = bus0;
        obs_bus1  = bus1;
        obs_flags = {if0.ram_ready, if1.ram_ready, if0.ram_oob, if1.ram_oob};
        exp_bus0  = wre ? rv : wdata;
        exp_bus1  = !wre ? wdata : ((exp_q.size() != 0) ? exp_q[0] : 16'hFFFF);
        exp_flags = {model_ready, model_ready, model_oob, model_oob};
        @(posedge clock);
        exp_q.delete();
        if (wre) exp_q.push_back(rv);
        if (model_ready) begin
            if (!inr) model_oob = 1'b1;
            else if (!wre) model_mem[idx] = wdata;
        end else begin
            clear_cnt++;
            if (clear_cnt == DEPTH) begin
                model_ready = 1'b1;
                foreach (model_mem[i]) model_mem[i] = 16'h0000;
            end
        end
        #1;
    endtask

    // Reads through the clear phase; reports the cycle ready was seen and model disagreements.
    task automatic wait_clear(input int write_cyc, output int ready_cyc, output int bad);
        ready_cyc = -1;
        bad       = 0;
        for (int k = 0; k < 40 && ready_cyc < 0; k++) begin
            if (k == write_cyc) drive_cycle(1'b0, 18'd1, 16'h7777);
            else drive_cycle(1'b1, 18'(k % DEPTH), 16'h0000);
            if (obs_bus0 !== exp_bus0 || obs_bus1 !== exp_bus1 || obs_flags !== exp_flags) bad++;
            if (obs_flags[3]) ready_cyc = k;
        end
    endtask

    task automatic pulse_reset_and_check(input string tag);
        tb_wre  = 1'b1;
        tb_drv  = 1'b0;
        tb_addr = 18'd7;
        rst_n   = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus0 !== 16'hFFFF || bus1 !== 16'hFFFF) begin
            failures++;
            $display("FAIL %s_bus_hiz got=%h/%h exp=ffff/ffff", tag, bus0, bus1);
        end
        checks++;
        if ({if0.ram_ready, if1.ram_ready, if0.ram_oob, if1.ram_oob} !== 4'b0000) begin
            failures++;
            $display("FAIL %s_flags got=%b exp=0000", tag,
                     {if0.ram_ready, if1.ram_ready, if0.ram_oob, if1.ram_oob});
        end
        @(posedge clock);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        pulse_reset_and_check("reset");
        checks++;
        if ({if0.dbg_state, if1.dbg_state} !== 2'b00) begin
            failures++;
            $display("FAIL reset_state got=%b exp=00", {if0.dbg_state, if1.dbg_state});
        end
    endtask

    task automatic test_clear();
        int rc, bad;
        wait_clear(3, rc, bad);
        checks++;
        if (rc !== 16) begin
            failures++;
            $display("FAIL clear_ready_cycle got=%0d exp=16", rc);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL clear_phase_cycles got=%0d bad exp=0", bad);
        end
        for (int a = 0; a < DEPTH; a++) begin
            drive_cycle(1'b1, 18'(a), 16'h0000);
            checks++;
            if (obs_bus0 !== 16'h0000 || obs_bus1 !== exp_bus1) begin
                failures++;
                $display("FAIL clear_read addr=%0d got=%h/%h exp=0000/%h", a, obs_bus0, obs_bus1, exp_bus1);
            end
        end
        checks++;
        if ({if0.dbg_state, if1.dbg_state} !== 2'b11) begin
            failures++;
            $display("FAIL serve_state got=%b exp=11", {if0.dbg_state, if1.dbg_state});
        end
    endtask

    task automatic test_lat0();
        logic [17:0] ra [3];
        logic [15:0] e0 [3];
        logic [15:0] e1 [3];
        ra = '{18'd9, 18'd5, 18'd0};
        e0 = '{16'hFFFF, 16'hABCD, 16'h0000};
        e1 = '{16'hFFFF, 16'hFFFF, 16'hABCD};
        drive_cycle(1'b0, 18'd5, 16'hABCD);
        drive_cycle(1'b1, 18'd5, 16'h0000);
        checks++;
        if (obs_bus0 !== 16'hABCD || obs_bus1 !== 16'hFFFF) begin
            failures++;
            $display("FAIL lat0_same_cycle got=%h/%h exp=abcd/ffff", obs_bus0, obs_bus1);
        end
        drive_cycle(1'b0, 18'd9, 16'hFFFF);
        checks++;
        if (obs_bus0 !== 16'hFFFF || obs_bus1 !== 16'hFFFF) begin
            failures++;
            $display("FAIL write_hiz got=%h/%h exp=ffff/ffff", obs_bus0, obs_bus1);
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, ra[i], 16'h0000);
            checks++;
            if (obs_bus0 !== e0[i] || obs_bus1 !== e1[i]) begin
                failures++;
                $display("FAIL lat0_read i=%0d got=%h/%h exp=%h/%h", i, obs_bus0, obs_bus1, e0[i], e1[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] ra [3];
        logic [15:0] e0 [3];
        logic [15:0] e1 [3];
        ra = '{18'd2, 18'd3, 18'd0};
        e0 = '{16'h1234, 16'h5678, 16'h0000};
        e1 = '{16'hFFFF, 16'h1234, 16'h5678};
        drive_cycle(1'b0, 18'd2, 16'h1234);
        drive_cycle(1'b0, 18'd3, 16'h5678);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, ra[i], 16'h0000);
            checks++;
            if (obs_bus0 !== e0[i] || obs_bus1 !== e1[i]) begin
                failures++;
                $display("FAIL b2b_read i=%0d got=%h/%h exp=%h/%h", i, obs_bus0, obs_bus1, e0[i], e1[i]);
            end
        end
    endtask

    task automatic test_oob();
        drive_cycle(1'b0, 18'h00010, 16'hBEEF);
        checks++;
        if (obs_flags !== 4'b1100) begin
            failures++;
            $display("FAIL oob_before got=%b exp=1100", obs_flags);
        end
        drive_cycle(1'b1, 18'd0, 16'h0000);
        checks++;
        if (obs_bus0 !== 16'h0000 || obs_flags !== 4'b1111) begin
            failures++;
            $display("FAIL oob_write_dropped got=%h/%b exp=0000/1111", obs_bus0, obs_flags);
        end
        drive_cycle(1'b0, 18'd4, 16'h1111);
        drive_cycle(1'b1, 18'd4, 16'h0000);
        checks++;
        if (obs_bus0 !== 16'h1111 || obs_flags !== 4'b1111) begin
            failures++;
            $display("FAIL oob_sticky got=%h/%b exp=1111/1111", obs_bus0, obs_flags);
        end
        drive_cycle(1'b1, 18'h20005, 16'h0000);
        checks++;
        if (obs_bus0 !== 16'h0000) begin
            failures++;
            $display("FAIL oob_read_zero got=%h exp=0000", obs_bus0);
        end
    endtask

    task automatic test_random();
        logic        w;
        logic [17:0] a;
        logic [15:0] d;
        for (int n = 0; n < 400; n++) begin
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 9) == 0) ? 18'($urandom) : 18'($urandom_range(0, DEPTH - 1));
            d = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            drive_cycle(w, a, d);
            checks++;
            if (obs_bus0 !== exp_bus0 || obs_bus1 !== exp_bus1 || obs_flags !== exp_flags) begin
                failures++;
                $display("FAIL random n=%0d wre=%0b addr=%h got=%h/%h/%b exp=%h/%h/%b", n, w, a,
                         obs_bus0, obs_bus1, obs_flags, exp_bus0, exp_bus1, exp_flags);
            end
        end
    endtask

    task automatic test_reset_mid_serve();
        int rc, bad;
        drive_cycle(1'b0, 18'd7, 16'h0F0F);
        drive_cycle(1'b1, 18'd7, 16'h0000);
        checks++;
        if (obs_bus0 !== 16'h0F0F) begin
            failures++;
            $display("FAIL serve_pre_reset got=%h exp=0f0f", obs_bus0);
        end
        pulse_reset_and_check("serve_reset");
        wait_clear(-1, rc, bad);
        checks++;
        if (rc !== 16 || bad !== 0) begin
            failures++;
            $display("FAIL serve_reclear got=%0d/%0d exp=16/0", rc, bad);
        end
        drive_cycle(1'b1, 18'd7, 16'h0000);
        drive_cycle(1'b1, 18'd7, 16'h0000);
        checks++;
        if (obs_bus0 !== 16'h0000 || obs_bus1 !== 16'h0000) begin
            failures++;
            $display("FAIL serve_recleared got=%h/%h exp=0000/0000", obs_bus0, obs_bus1);
        end
    endtask

    task automatic test_reset_mid_clear();
        int rc, bad;
        pulse_reset_and_check("clear_reset_a");
        for (int k = 0; k < 5; k++) drive_cycle(1'b1, 18'(k), 16'h0000);
        pulse_reset_and_check("clear_reset_b");
        wait_clear(-1, rc, bad);
        checks++;
        if (rc !== 16 || bad !== 0) begin
            failures++;
            $display("FAIL clear_restart got=%0d/%0d exp=16/0", rc, bad);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clear();
        test_lat0();
        test_back_to_back();
        test_oob();
        test_random();
        test_reset_mid_serve();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
